// File: rtl/keyboard_pkg.sv
// Purpose: shared definitions for the keyboard debouncer: default parameter values,
//          the "no key" code and the key-code type.
// Ports:   none (package).
// Build option: KBD_AUTOREPEAT_EN (see keyboard_controller.sv).
package keyboard_pkg;

  localparam int unsigned DEFAULT_CLOCKDIVISOR         = 1000;
  localparam int unsigned DEFAULT_STEADYCOUNTTHRESHOLD = 7;
  localparam int unsigned DEFAULT_REPEATTICKS          = 32;

  typedef logic [7:0] keycode_t;

  localparam keycode_t KEY_NONE = 8'h00;

endpackage

// File: rtl/clock_divider.sv
// Purpose: free-running modulo-DIVISOR counter producing a one-clk sample tick.
//          tick is combinational and high while the counter sits at DIVISOR-1, so the
//          consuming logic samples on the edge that wraps the counter.
// Ports:
//   clk   in  1  system clock, rising edge
//   nRST  in  1  synchronous active-high reset (counter returns to 0)
//   tick  out 1  high for one clk every DIVISOR clks
module clock_divider #(
  parameter int unsigned DIVISOR = 1000
) (
  input  logic clk,
  input  logic nRST,
  output logic tick
);

  localparam int unsigned CLOCKDIVIDERWIDTH = $clog2(DIVISOR);
  localparam logic [CLOCKDIVIDERWIDTH-1:0] DIVLAST = CLOCKDIVIDERWIDTH'(DIVISOR - 1);

  logic [CLOCKDIVIDERWIDTH-1:0] r_div_cnt;

  always_ff @(posedge clk) begin
    if (nRST) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == DIVLAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + CLOCKDIVIDERWIDTH'(1);
    end
  end

  assign tick = (r_div_cnt == DIVLAST);

endmodule

// File: rtl/keyboard_controller.sv
// Purpose: debounces an 8-bit parallel key-code bus. keyValues is sampled once per divider
//          tick; a non-zero code seen unchanged for STEADYCOUNTTHRESHOLD consecutive samples
//          is latched to savedByte and keyReady pulses for one clk. Held keys do not
//          re-report unless built with KBD_AUTOREPEAT_EN, which re-pulses keyReady every
//          REPEATTICKS ticks while the key stays down.
// Ports:
//   clk        in  1  system clock, rising edge
//   nRST       in  1  synchronous active-high reset
//   keyValues  in  8  raw key code, 8'h00 = no key
//   savedByte  out 8  last reported key code
//   keyReady   out 1  one-clk pulse coincident with a savedByte update (or a repeat)
// Build option: KBD_AUTOREPEAT_EN enables the auto-repeat counter.
module keyboard_controller
  import keyboard_pkg::*;
#(
  parameter int unsigned CLOCKDIVISOR         = DEFAULT_CLOCKDIVISOR,
  parameter int unsigned STEADYCOUNTTHRESHOLD = DEFAULT_STEADYCOUNTTHRESHOLD,
  parameter int unsigned REPEATTICKS          = DEFAULT_REPEATTICKS
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic [7:0] keyValues,
  output logic [7:0] savedByte,
  output logic       keyReady
);

  localparam int unsigned STEADYWIDTH = $clog2(STEADYCOUNTTHRESHOLD + 1);
  localparam logic [STEADYWIDTH-1:0] STEADYMAX = STEADYWIDTH'(STEADYCOUNTTHRESHOLD);

  logic                   w_tick;
  logic                   w_same;
  logic                   w_report;
  keycode_t               r_last_sample;
  logic [STEADYWIDTH-1:0] r_steady_cnt;
  logic                   r_reported;
  keycode_t               r_saved_byte;
  logic                   r_key_ready;

  clock_divider #(
    .DIVISOR(CLOCKDIVISOR)
  ) u_clock_divider (
    .clk (clk),
    .nRST(nRST),
    .tick(w_tick)
  );

  assign w_same   = (keyValues == r_last_sample);
  // Uses pre-edge state, so a report can fire on the same edge as a value-changing tick.
  assign w_report = (r_steady_cnt == STEADYMAX) && !r_reported && (r_last_sample != KEY_NONE);

`ifdef KBD_AUTOREPEAT_EN
  localparam logic [15:0] REPEATLAST = 16'(REPEATTICKS - 1);
  logic [15:0] r_rep_cnt;
`endif

  always_ff @(posedge clk) begin
    if (nRST) begin
      r_last_sample <= KEY_NONE;
      r_steady_cnt  <= '0;
      r_reported    <= 1'b0;
      r_saved_byte  <= KEY_NONE;
      r_key_ready   <= 1'b0;
`ifdef KBD_AUTOREPEAT_EN
      r_rep_cnt     <= '0;
`endif
    end else begin
      r_key_ready <= 1'b0;

      if (w_report) begin
        r_key_ready  <= 1'b1;
        r_saved_byte <= r_last_sample;
        r_reported   <= 1'b1;
      end

      if (w_tick) begin
        r_last_sample <= keyValues;
        if (w_same) begin
          if (r_steady_cnt != STEADYMAX) begin
            r_steady_cnt <= r_steady_cnt + STEADYWIDTH'(1);
          end
        end else begin
          // Placed after the report so a simultaneous value change wins over reported<=1.
          r_steady_cnt <= '0;
          r_reported   <= 1'b0;
        end

`ifdef KBD_AUTOREPEAT_EN
        if (!w_same) begin
          r_rep_cnt <= '0;
        end else if (r_reported && (r_last_sample != KEY_NONE)) begin
          if (r_rep_cnt == REPEATLAST) begin
            r_rep_cnt   <= '0;
            r_key_ready <= 1'b1;
          end else begin
            r_rep_cnt <= r_rep_cnt + 16'd1;
          end
        end
`endif
      end
    end
  end

  assign savedByte = r_saved_byte;
  assign keyReady  = r_key_ready;

endmodule

// File: tb/tb_keyboard_controller.sv
// Directed bench for keyboard_controller with CLOCKDIVISOR=10 and threshold 7 (default build,
// auto-repeat disabled). Cycle 1 is the first posedge after reset is released.
module tb_keyboard_controller;
  import keyboard_pkg::*;

  logic     clk  = 1'b0;
  logic     nRST = 1'b1;
  keycode_t keyValues = 8'h00;
  keycode_t savedByte;
  logic     keyReady;

  always #5 clk = ~clk;

  keyboard_controller #(
    .CLOCKDIVISOR        (10),
    .STEADYCOUNTTHRESHOLD(7),
    .REPEATTICKS         (32)
  ) dut (
    .clk      (clk),
    .nRST     (nRST),
    .keyValues(keyValues),
    .savedByte(savedByte),
    .keyReady (keyReady)
  );

  int       n_checks   = 0;
  int       n_errors   = 0;
  int       cyc        = 0;
  int       pulses     = 0;
  int       last_pulse = -1;
  keycode_t pulse_byte = 8'h00;

  typedef struct {
    logic     do_rst;
    keycode_t key;
    int       cycles;
    int       exp_pulses;
    int       exp_last;
    keycode_t exp_saved;
  } seg_t;

  seg_t tbl[7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    if (keyReady === 1'b1) begin
      pulses++;
      last_pulse = cyc;
      pulse_byte = savedByte;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    nRST = 1'b1;
    step();
    nRST = 1'b0;
    cyc = 0;
    pulses = 0;
    last_pulse = -1;
  endtask

  task automatic clear_pulses();
    pulses = 0;
    last_pulse = -1;
  endtask

  initial begin
    //            rst   key    cycles pulses last exp_saved
    tbl[0] = '{1'b1, 8'h48, 90,  1, 81,  8'h48};  // constant press
    tbl[1] = '{1'b1, 8'h48, 300, 1, 81,  8'h48};  // long hold, one report
    tbl[2] = '{1'b1, 8'h00, 200, 0, -1,  8'h00};  // idle never reports
    tbl[3] = '{1'b1, 8'h48, 90,  1, 81,  8'h48};  // press
    tbl[4] = '{1'b0, 8'h00, 100, 0, -1,  8'h48};  // release, savedByte holds
    tbl[5] = '{1'b0, 8'h48, 100, 1, 271, 8'h48};  // same code again reports again
    tbl[6] = '{1'b0, 8'h31, 100, 1, 371, 8'h31};  // direct change to new code

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].do_rst) begin
        do_reset();
        check($sformatf("seg%0d_rst_saved", i), int'(savedByte), 0);
        check($sformatf("seg%0d_rst_ready", i), int'(keyReady), 0);
      end
      keyValues = tbl[i].key;
      clear_pulses();
      run(tbl[i].cycles);
      check($sformatf("seg%0d_pulses", i), pulses, tbl[i].exp_pulses);
      if (tbl[i].exp_pulses > 0) begin
        check($sformatf("seg%0d_pulse_cyc", i), last_pulse, tbl[i].exp_last);
        check($sformatf("seg%0d_pulse_byte", i), int'(pulse_byte), int'(tbl[i].exp_saved));
      end
      check($sformatf("seg%0d_saved", i), int'(savedByte), int'(tbl[i].exp_saved));
    end

    // Glitch: 8'h49 is the sample at cycle 50; count restarts, report at 131.
    do_reset();
    keyValues = 8'h48;
    run(49);
    keyValues = 8'h49;
    run(1);
    keyValues = 8'h48;
    run(151);
    check("glitch_pulses", pulses, 1);
    check("glitch_pulse_cyc", last_pulse, 131);
    check("glitch_pulse_byte", int'(pulse_byte), 8'h48);

    // Change between samples (cycles 21..25) is never seen.
    do_reset();
    keyValues = 8'h48;
    run(20);
    keyValues = 8'h55;
    run(5);
    keyValues = 8'h48;
    run(65);
    check("hidden_pulses", pulses, 1);
    check("hidden_pulse_cyc", last_pulse, 81);

    // Reset at cycle 60 restarts everything; report lands at 60+81.
    do_reset();
    keyValues = 8'h48;
    run(59);
    nRST = 1'b1;
    step();
    check("midrst_saved", int'(savedByte), 0);
    check("midrst_ready", int'(keyReady), 0);
    nRST = 1'b0;
    run(100);
    check("midrst_pulses", pulses, 1);
    check("midrst_pulse_cyc", last_pulse, 141);
    check("midrst_saved_after", int'(savedByte), 8'h48);

    // Reset after a report clears savedByte; next report 81 cycles after the reset edge.
    nRST = 1'b1;
    step();
    check("rst2_saved", int'(savedByte), 0);
    nRST = 1'b0;
    clear_pulses();
    run(100);
    check("rst2_pulses", pulses, 1);
    check("rst2_pulse_cyc", last_pulse, 242);

    // Reset on the edge a report would fire: no pulse survives.
    do_reset();
    keyValues = 8'h48;
    run(80);
    nRST = 1'b1;
    step();
    check("pending_ready", int'(keyReady), 0);
    nRST = 1'b0;
    clear_pulses();
    run(50);
    check("pending_pulses", pulses, 0);
    check("pending_saved", int'(savedByte), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
